// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment display drivers.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied by each top level.
package sevenseg_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    // Active-high "nothing lit" pattern.
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with dead-time between slots,
// a per-frame input snapshot, per-digit masking and leading-zero blanking.
module sevenseg_mux_n
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int ON_CYCLES      = 24000,
    parameter int BLANK_CYCLES   = 240,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    lz_blank,
    output logic [6:0]              sevenseg,
    output logic [NUM_DIGITS-1:0]   en,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] EN_DARK  = EN_ACTIVE_LOW ? '1 : '0;

    state_t                      r_state;
    logic [CW-1:0]               r_cnt;
    logic [IW-1:0]               r_idx;
    logic [NUM_DIGITS-1:0][3:0]  r_snap;
    logic [NUM_DIGITS-1:0]       r_lz_flag;
    logic [6:0]                  r_seg;
    logic [NUM_DIGITS-1:0]       r_en;
    logic                        r_tick;

    logic [NUM_DIGITS-1:0]       w_lz_next;
    logic [NUM_DIGITS-1:0]       w_lit;
    logic [3:0]                  w_nibble;
    logic [6:0]                  w_seg_ah;
    logic [6:0]                  w_seg_out;
    logic [NUM_DIGITS-1:0]       w_en_ah;
    logic [NUM_DIGITS-1:0]       w_en_out;
    logic                        w_show_lit;

    // Leading-zero flags from the incoming digits; digit 0 is never flagged.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_lz_next  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (digits[4*i +: 4] == 4'h0);
            w_lz_next[i] = zero_above;
        end
    end

    // Mask and blanking enable are live; only the zero flags are frame-coherent.
    assign w_lit      = digit_mask & ~({NUM_DIGITS{lz_blank}} & r_lz_flag);
    assign w_nibble   = r_snap[r_idx];
    assign w_show_lit = (r_state == S_SHOW) && w_lit[r_idx];

    sevenseg_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_ah)
    );

    always_comb begin
        w_en_ah = '0;
        if (w_show_lit)
            w_en_ah[r_idx] = 1'b1;
    end

    assign w_seg_out = w_show_lit ? (SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah) : SEG_DARK;
    assign w_en_out  = EN_ACTIVE_LOW ? ~w_en_ah : w_en_ah;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_BLANK;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_snap    <= '0;
            r_lz_flag <= '0;
            r_seg     <= SEG_DARK;
            r_en      <= EN_DARK;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SHOW;
                        if (r_idx == '0) begin
                            r_snap    <= digits;
                            r_lz_flag <= w_lz_next;
                            r_tick    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == ON_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_BLANK;
                        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_BLANK;
                    r_cnt   <= '0;
                end
            endcase
            // Segments and enables share one register stage so they switch together.
            r_seg <= w_seg_out;
            r_en  <= w_en_out;
        end
    end

    assign sevenseg   = r_seg;
    assign en         = r_en;
    assign frame_tick = r_tick;

endmodule
